// File: rtl/color_vote.sv
// color_vote: per-frame dominant-color detector with saturating per-class vote counters.
// Optional hysteresis on the reported color is enabled by defining COLOR_VOTE_HYST_EN.
module color_vote #(
  parameter int DATA_WIDTH  = 8,
  parameter int THRESH      = 50,
  parameter int CNT_WIDTH   = 20,
  parameter int HYST_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] red,
  input  logic [DATA_WIDTH-1:0] green,
  input  logic [DATA_WIDTH-1:0] blue,
  input  logic                  sof,
  input  logic                  eof,
  output logic [1:0]            pix_class,
  output logic                  pix_valid,
  output logic [1:0]            main,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  localparam logic [DATA_WIDTH-1:0] TH = DATA_WIDTH'(THRESH);

  function automatic logic [1:0] classify(input logic [DATA_WIDTH-1:0] r,
                                          input logic [DATA_WIDTH-1:0] g,
                                          input logic [DATA_WIDTH-1:0] b);
    logic [1:0] c;
    c = 2'd3;
    if ((r > TH) || (g > TH) || (b > TH)) begin
      if (r > b)      c = (r > g) ? 2'd0 : 2'd1;
      else if (b > r) c = (b > g) ? 2'd2 : 2'd1;
    end
    return c;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Strict '>' keeps ties on the lowest class index.
  function automatic logic [1:0] pick(input logic [3:0][CNT_WIDTH-1:0] c);
    logic [1:0] w;
    w = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (c[i] > c[w]) w = 2'(i);
    end
    return w;
  endfunction

  state_t                      state_q, state_d;
  logic [3:0][CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [1:0]                  pix_class_q, pix_class_d;
  logic                        pix_valid_q, pix_valid_d;
  logic [1:0]                  main_q, main_d;
  logic                        out_valid_q, out_valid_d;
  logic                        frame_err_q, frame_err_d;
  logic                        xfer;
  logic [1:0]                  cls;
  logic [1:0]                  frame_win;
`ifdef COLOR_VOTE_HYST_EN
  localparam logic [3:0] HYST_N = 4'(HYST_FRAMES);
  logic [1:0]                  cand_q, cand_d;
  logic [3:0]                  streak_q, streak_d;
  logic [3:0]                  streak_nx;
`endif

  assign xfer      = in_valid & in_ready;
  assign cls       = classify(red, green, blue);
  assign frame_win = pick(cnt_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer && sof) state_d = eof ? REPORT : ACCUM;
      ACCUM:   if (xfer && eof) state_d = REPORT;
      REPORT:  if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q != REPORT);
    out_valid = out_valid_q;
    main      = main_q;
    pix_class = pix_class_q;
    pix_valid = pix_valid_q;
    frame_err = frame_err_q;
  end

  always_comb begin
    cnt_d       = cnt_q;
    pix_class_d = pix_class_q;
    pix_valid_d = 1'b0;
    frame_err_d = frame_err_q;
    out_valid_d = out_valid_q;
    main_d      = main_q;
`ifdef COLOR_VOTE_HYST_EN
    cand_d      = cand_q;
    streak_d    = streak_q;
    streak_nx   = streak_q;
`endif
    if (xfer) begin
      pix_class_d = cls;
      pix_valid_d = 1'b1;
      if (sof) begin
        cnt_d      = '0;
        cnt_d[cls] = CNT_WIDTH'(1);
        if (state_q == ACCUM) frame_err_d = 1'b1;
      end else if (state_q == ACCUM) begin
        cnt_d[cls] = sat_inc(cnt_q[cls]);
      end
    end
    // The cycle after entering REPORT, counts are final: latch the result once.
    if (state_q == REPORT) begin
      if (!out_valid_q) begin
        out_valid_d = 1'b1;
`ifdef COLOR_VOTE_HYST_EN
        if (frame_win == main_q) begin
          streak_d = 4'd0;
        end else begin
          if (frame_win == cand_q) begin
            streak_nx = streak_q + 4'd1;
          end else begin
            cand_d    = frame_win;
            streak_nx = 4'd1;
          end
          if (streak_nx >= HYST_N) begin
            main_d   = frame_win;
            streak_d = 4'd0;
          end else begin
            streak_d = streak_nx;
          end
        end
`else
        main_d = frame_win;
`endif
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      pix_class_q <= 2'd3;
      pix_valid_q <= 1'b0;
      main_q      <= 2'd3;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef COLOR_VOTE_HYST_EN
      cand_q      <= 2'd3;
      streak_q    <= 4'd0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      pix_class_q <= pix_class_d;
      pix_valid_q <= pix_valid_d;
      main_q      <= main_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
`ifdef COLOR_VOTE_HYST_EN
      cand_q      <= cand_d;
      streak_q    <= streak_d;
`endif
    end
  end

endmodule

// File: doc/color_vote.md
# color_vote

Streaming, frame-level dominant-color detector. Classifies each incoming RGB pixel with the team's primary-color rule, keeps a saturating vote count per class across a frame delimited by start/end markers, and reports the winning class once per frame over a valid/ready handshake. It sits between the pixel source (camera/VGA read path) and the display/LED logic that consumes a single dominant-color code per frame.

## Interface
- DATA_WIDTH, 8, bits per color channel
- THRESH, 50, a pixel is colored only if some channel is strictly greater than THRESH
- CNT_WIDTH, 20, width of each vote counter (saturating)
- HYST_FRAMES, 2, consecutive wins needed to change main (only with COLOR_VOTE_HYST_EN; legal range 1..15)

- clk  in  1  clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  pixel present on red/green/blue/sof/eof
- in_ready  out  1  block accepts pixel; transfer = in_valid & in_ready
- red, green, blue  in  DATA_WIDTH each  pixel channels, unsigned
- sof  in  1  pixel is first of frame
- eof  in  1  pixel is last of frame
- pix_class  out  2  registered class of last accepted pixel
- pix_valid  out  1  one-cycle pulse, pix_class updated
- main  out  2  reported dominant color: 0 red, 1 green, 2 blue, 3 none
- out_valid  out  1  main holds a new frame result
- out_ready  in  1  consumer accepts result
- frame_err  out  1  sticky; set when sof arrives mid-frame

## Operation
- Pixel rule (per accepted pixel): if red, green or blue > THRESH: if red > blue then (red > green ? 0 : 1); else if blue > red then (blue > green ? 2 : 1); else 3. Otherwise 3. Equal red/blue always yields 3, regardless of green.
- Four counters cnt[0..3], CNT_WIDTH bits, saturate at all-ones, never wrap.
- FSM states IDLE, ACCUM, REPORT.
- IDLE: in_ready=1. Transfer with sof=0 is classified (pix_valid pulses) but not counted. Transfer with sof=1: counters load 0 except the pixel's class loads 1; go ACCUM, or REPORT if eof=1 in same beat.
- ACCUM: in_ready=1. Transfer increments its class counter. Transfer with eof=1 -> REPORT. Transfer with sof=1 (eof=0): set frame_err, reload counters as in IDLE, stay ACCUM (frame restarted). sof=1 and eof=1 together: restart then REPORT with single-pixel counts; frame_err set.
- REPORT: in_ready=0, out_valid=1, main stable. out_valid & out_ready -> IDLE, main keeps its value.
- Winner = argmax over cnt[0..3]; ties go to the lowest index (red > green > blue > none).
- frame_err cleared only by reset.

## Timing
- Reset values: in_ready 1 (deasserted only in REPORT), pix_class 3, pix_valid 0, main 3, out_valid 0, frame_err 0, counters 0, state IDLE.
- pix_class/pix_valid: 1-cycle latency after transfer.
- Result latency: eof transfer at edge N -> out_valid=1 and main valid after edge N+1 (counts include the eof pixel).
- Earliest next frame transfer: cycle after out_valid & out_ready handshake.
- out_ready held high: out_valid is a one-cycle pulse; no combinational path from in_valid to in_ready.
- reset asserted mid-frame or in REPORT: immediate return to reset values; partial frame discarded, no result.

## Configuration
- COLOR_VOTE_HYST_EN defined: a candidate register and 4-bit win-streak counter are added. Frame winner equal to current main: streak cleared. Winner equal to candidate: streak+1, else candidate=winner, streak=1. When streak reaches HYST_FRAMES, main=winner, streak cleared. out_valid still asserts every frame, main may be unchanged. Reset: candidate 3, streak 0.
- Not defined: main = frame winner every frame; no hysteresis registers.

## Test plan
- Single pixel sof=eof=1, R=128 G=76 B=88 -> pix_class 0, out_valid next cycle, main 0, frame_err 0.
- 10-pixel frame: 3x(79,253,28), 3x(128,76,255), 4x(10,10,10) -> main 3 (none wins 4 votes); repeat with 2x dark -> tie 3 green vs 3 blue, main 1.
- Pixel (200,30,200) -> class 3; pixel (50,50,50) -> class 3 (threshold strict).
- Hold out_ready=0 for 5 cycles in REPORT -> in_ready=0, main stable; drive in_valid during it -> no count change; release -> IDLE.
- sof mid-frame after 4 red pixels, then 2 blue with eof -> frame_err=1, main 2; reset mid-ACCUM -> all outputs at reset values, no out_valid.
- COLOR_VOTE_HYST_EN, HYST_FRAMES=2: frames red, blue, red, blue, blue -> main 3, 0 on the second red? no: 3,3,3,3,2; with macro off -> 0,2,0,2,2. Counter saturation with CNT_WIDTH=4: 20 red pixels -> cnt[0]=15, main 0.
